// File: rtl/layered_pixel_scanner_pkg.sv
// Shared DinoGame constants: default frame geometry, colour depth and the
// scanner FSM state encoding used by layered_pixel_scanner.
package layered_pixel_scanner_pkg;

  localparam int DINO_XMAX = 159;
  localparam int DINO_YMAX = 119;
  localparam int DINO_CW   = 8;
  localparam int DINO_COLW = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPLAY = 2'd2
  } scanState_t;

endpackage

// File: rtl/layered_pixel_scanner_priority_mux.sv
// Priority compositor: the lowest-indexed layer that hits wins, and the
// background colour shows through when no layer hits. Purely combinational.
module layer_priority_mux #(
  parameter int NL   = 4,
  parameter int COLW = 3
) (
  input  logic [NL-1:0]      hit,
  input  logic [NL*COLW-1:0] color,
  input  logic [COLW-1:0]    bgColor,
  output logic [COLW-1:0]    outColor
);

  // Walk from the highest index down so the lowest hitting layer is written last.
  always_comb begin
    outColor = bgColor;
    for (int i = NL - 1; i >= 0; i--) begin
      if (hit[i]) outColor = color[i*COLW +: COLW];
    end
  end

endmodule

// File: rtl/layered_pixel_scanner.sv
// Raster scanner that issues coordinates to a set of fixed-latency layer
// sources, composites their answers into one colour per pixel and presents
// the result on a ready/valid plot port. A back-pressured pixel is held while
// the in-flight pixels are discarded and re-issued from the held pixel's
// raster successor, so every pixel reaches the sink exactly once.
module layered_pixel_scanner
  import layered_pixel_scanner_pkg::*;
#(
  parameter int XMAX = DINO_XMAX,
  parameter int YMAX = DINO_YMAX,
  parameter int CW   = DINO_CW,
  parameter int COLW = DINO_COLW,
  parameter int NL   = 4,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               clear_mode,
  input  logic [COLW-1:0]    bg_color,
  input  logic [NL-1:0]      layer_hit,
  input  logic [NL*COLW-1:0] layer_color,
  output logic [CW-1:0]      req_x,
  output logic [CW-1:0]      req_y,
  output logic [CW-1:0]      plot_x,
  output logic [CW-1:0]      plot_y,
  output logic [COLW-1:0]    plot_color,
  output logic               plot,
  input  logic               plot_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [CW-1:0] XLAST = XMAX[CW-1:0];
  localparam logic [CW-1:0] YLAST = YMAX[CW-1:0];
  localparam int DEPTH = (LAT > 0) ? LAT : 1;

  scanState_t state, stateNext;

  logic [CW-1:0]   reqX, reqY;
  logic            lastIssued;
  logic            clearLat;
  logic            issue;
  logic            stall, acceptPix, acceptLast;

  logic [CW-1:0]   pipeX [DEPTH];
  logic [CW-1:0]   pipeY [DEPTH];
  logic [DEPTH-1:0] pipeVld;

  logic            tapVld;
  logic [CW-1:0]   tapX, tapY;
  logic [COLW-1:0] muxColor, pixColor;

  function automatic logic [CW-1:0] succX(input logic [CW-1:0] x);
    return (x == XLAST) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [CW-1:0] succY(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (x != XLAST) return y;
    return (y == YLAST) ? '0 : y + 1'b1;
  endfunction

  assign stall      = plot && !plot_ready;
  assign acceptPix  = plot && plot_ready;
  assign acceptLast = acceptPix && (plot_x == XLAST) && (plot_y == YLAST);
  assign busy       = (state != ST_IDLE);
  assign req_x      = reqX;
  assign req_y      = reqY;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= stateNext;
  end

  // Next-state logic; a coordinate is issued only while scanning, permitted and unstalled.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start && enable) stateNext = ST_SCAN;
      end
      ST_SCAN: begin
        if (acceptLast)  stateNext = ST_IDLE;
        else if (stall)  stateNext = ST_REPLAY;
        else             issue = enable && !lastIssued;
      end
      ST_REPLAY: begin
        if (acceptLast)     stateNext = ST_IDLE;
        else if (acceptPix) stateNext = ST_SCAN;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Issue coordinate: restart at the origin, rewind behind a held pixel, or advance in raster order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      reqX       <= '0;
      reqY       <= '0;
      lastIssued <= 1'b0;
      clearLat   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (frame_start && enable) begin
        reqX       <= '0;
        reqY       <= '0;
        lastIssued <= 1'b0;
        clearLat   <= clear_mode;
      end
    end else if (stall) begin
      reqX       <= succX(plot_x);
      reqY       <= succY(plot_x, plot_y);
      lastIssued <= (plot_x == XLAST) && (plot_y == YLAST);
    end else if (issue) begin
      reqX       <= succX(reqX);
      reqY       <= succY(reqX, reqY);
      lastIssued <= (reqX == XLAST) && (reqY == YLAST);
    end
  end

  // Coordinate delay line matching the layer-source latency; a stall flushes every valid bit.
  always_ff @(posedge clk) begin
    if (!resetn || stall) begin
      pipeVld <= '0;
    end else begin
      pipeVld[0] <= issue;
      for (int k = 1; k < DEPTH; k++) pipeVld[k] <= pipeVld[k-1];
    end
    pipeX[0] <= reqX;
    pipeY[0] <= reqY;
    for (int k = 1; k < DEPTH; k++) begin
      pipeX[k] <= pipeX[k-1];
      pipeY[k] <= pipeY[k-1];
    end
  end

  generate
    if (LAT == 0) begin : gTapDirect
      assign tapVld = issue;
      assign tapX   = reqX;
      assign tapY   = reqY;
    end else begin : gTapLine
      assign tapVld = pipeVld[LAT-1];
      assign tapX   = pipeX[LAT-1];
      assign tapY   = pipeY[LAT-1];
    end
  endgenerate

  layer_priority_mux #(
    .NL  (NL),
    .COLW(COLW)
  ) uMux (
    .hit     (layer_hit),
    .color   (layer_color),
    .bgColor (bg_color),
    .outColor(muxColor)
  );

  assign pixColor = clearLat ? bg_color : muxColor;

  // Output register: holds while back-pressured, otherwise captures the pixel at the delay-line tap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_color <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acceptLast;
      if (!stall) begin
        plot <= tapVld;
        if (tapVld) begin
          plot_x     <= tapX;
          plot_y     <= tapY;
          plot_color <= pixColor;
        end
      end
    end
  end

endmodule

// File: tb/tb_layered_pixel_scanner.sv
// Bench for layered_pixel_scanner on a 4x2 frame with two-cycle layer sources.
module tb_layered_pixel_scanner;

  localparam int XMAX = 3;
  localparam int YMAX = 1;
  localparam int CW   = 8;
  localparam int COLW = 3;
  localparam int NL   = 4;
  localparam int LAT  = 2;
  localparam int NPIX = (XMAX + 1) * (YMAX + 1);

  logic               clk = 1'b0;
  logic               resetn, enable, frame_start, clear_mode, plot_ready;
  logic [COLW-1:0]    bg_color;
  logic [NL-1:0]      layer_hit;
  logic [NL*COLW-1:0] layer_color;
  logic [CW-1:0]      req_x, req_y, plot_x, plot_y;
  logic [COLW-1:0]    plot_color;
  logic               plot, busy, frame_done;

  int errors = 0;
  int checks = 0;

  logic [NL-1:0]      hitTab [0:YMAX][0:XMAX];
  logic [NL*COLW-1:0] colTab [0:YMAX][0:XMAX];
  logic [CW-1:0]      expX [NPIX];
  logic [CW-1:0]      expY [NPIX];
  logic [COLW-1:0]    expC [NPIX];

  always #5 clk = ~clk;

  layered_pixel_scanner #(
    .XMAX(XMAX), .YMAX(YMAX), .CW(CW), .COLW(COLW), .NL(NL), .LAT(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_start(frame_start),
    .clear_mode(clear_mode), .bg_color(bg_color), .layer_hit(layer_hit),
    .layer_color(layer_color), .req_x(req_x), .req_y(req_y), .plot_x(plot_x),
    .plot_y(plot_y), .plot_color(plot_color), .plot(plot), .plot_ready(plot_ready),
    .busy(busy), .frame_done(frame_done)
  );

  // Layer sources: answer for the coordinate requested LAT cycles earlier.
  logic [CW-1:0] d1x = '0, d1y = '0, d2x = '0, d2y = '0;
  always @(posedge clk) begin
    d1x <= req_x; d1y <= req_y;
    d2x <= d1x;   d2y <= d1y;
  end
  assign layer_hit   = hitTab[d2y[0]][d2x[1:0]];
  assign layer_color = colTab[d2y[0]][d2x[1:0]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference colour: first hitting layer in index order, else background; clear forces background.
  function automatic logic [COLW-1:0] refColor(input logic clr, input logic [NL-1:0] h,
                                              input logic [NL*COLW-1:0] c, input logic [COLW-1:0] bg);
    logic [COLW-1:0] r;
    r = bg;
    if (!clr) begin
      for (int i = 0; i < NL; i++) begin
        if (h[i]) begin
          r = c[i*COLW +: COLW];
          break;
        end
      end
    end
    return r;
  endfunction

  // mode 0: no hits, 1: directed overlap, 2: every layer hits, 3: random
  task automatic setTables(input int mode);
    for (int y = 0; y <= YMAX; y++) begin
      for (int x = 0; x <= XMAX; x++) begin
        colTab[y][x] = (NL*COLW)'($urandom);
        case (mode)
          0, 1:    hitTab[y][x] = '0;
          2:       hitTab[y][x] = '1;
          default: hitTab[y][x] = NL'($urandom_range(15));
        endcase
      end
    end
    if (mode == 1) begin
      hitTab[0][2] = 4'b1010;
      colTab[0][2] = {3'd6, 3'd0, 3'd5, 3'd0};
      hitTab[1][1] = 4'b1000;
      colTab[1][1] = {3'd6, 3'd1, 3'd2, 3'd3};
    end
  endtask

  task automatic runFrame(input logic clr, input int readyPct, input int enPct,
                          input logic stallDirected, input logic spamStart, input int resetAtPix);
    int idx, cyc, firstPlotCyc, lastAccCyc, stallLeft;
    logic finished, aborted, sawDone, stallNow;
    idx = 0; cyc = 0; firstPlotCyc = -1; lastAccCyc = -1; stallLeft = 3;
    finished = 1'b0; aborted = 1'b0;

    for (int y = 0; y <= YMAX; y++) begin
      for (int x = 0; x <= XMAX; x++) begin
        expX[y*(XMAX+1)+x] = CW'(x);
        expY[y*(XMAX+1)+x] = CW'(y);
        expC[y*(XMAX+1)+x] = refColor(clr, hitTab[y][x], colTab[y][x], bg_color);
      end
    end

    @(negedge clk);
    enable = 1'b1; frame_start = 1'b1; clear_mode = clr; plot_ready = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; clear_mode = ~clr;
    check("busyStart", 32'(busy), 32'd1);

    while (!finished && cyc < 400) begin
      if (frame_done) begin
        check("doneCycle", cyc, lastAccCyc + 1);
        check("donePixels", idx, NPIX);
        frame_start = 1'b0;
        finished = 1'b1;
      end else if (resetAtPix >= 0 && plot && idx == resetAtPix) begin
        resetn = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        check("rstPlot", 32'(plot), 32'd0);
        check("rstBusy", 32'(busy), 32'd0);
        check("rstDone", 32'(frame_done), 32'd0);
        check("rstReqX", 32'(req_x), 32'd0);
        check("rstPlotX", 32'(plot_x), 32'd0);
        resetn = 1'b1;
        sawDone = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (frame_done) sawDone = 1'b1;
        end
        check("noDoneAfterReset", 32'(sawDone), 32'd0);
        finished = 1'b1; aborted = 1'b1;
      end else begin
        if (plot && firstPlotCyc < 0) begin
          firstPlotCyc = cyc;
          if (enPct == 100) check("firstLatency", cyc, LAT + 1);
        end
        stallNow = stallDirected && plot && plot_x == 1 && plot_y == 0 && stallLeft > 0;
        if (stallNow) stallLeft--;
        plot_ready  = stallNow ? 1'b0 : ($urandom_range(99) < readyPct);
        enable      = ($urandom_range(99) < enPct);
        frame_start = spamStart ? 1'($urandom_range(1)) : 1'b0;
        if (plot && plot_ready) begin
          if (idx < NPIX) begin
            check("pixX", 32'(plot_x), 32'(expX[idx]));
            check("pixY", 32'(plot_y), 32'(expY[idx]));
            check("pixColor", 32'(plot_color), 32'(expC[idx]));
          end else begin
            check("extraPixel", idx, NPIX - 1);
          end
          idx++;
          lastAccCyc = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end

    check("frameFinished", 32'(finished), 32'd1);
    if (finished && !aborted) begin
      @(negedge clk);
      check("donePulse", 32'(frame_done), 32'd0);
      check("busyIdle", 32'(busy), 32'd0);
      if (stallDirected) check("stallApplied", stallLeft, 0);
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; frame_start = 1'b0; clear_mode = 1'b0;
    plot_ready = 1'b1; bg_color = 3'd3;
    setTables(0);
    repeat (3) @(negedge clk);
    check("rstPlot0", 32'(plot), 32'd0);
    check("rstBusy0", 32'(busy), 32'd0);
    check("rstDone0", 32'(frame_done), 32'd0);
    check("rstReqX0", 32'(req_x), 32'd0);
    check("rstReqY0", 32'(req_y), 32'd0);
    check("rstPlotX0", 32'(plot_x), 32'd0);
    check("rstPlotY0", 32'(plot_y), 32'd0);
    check("rstColor0", 32'(plot_color), 32'd0);
    resetn = 1'b1;

    // Plain frame, no hits: background everywhere, first plot LAT+1 after acceptance.
    bg_color = 3'd3; setTables(0);
    runFrame(1'b0, 100, 100, 1'b0, 1'b0, -1);

    // Overlapping layers 1 and 3 at (2,0); layer 3 alone at (1,1).
    bg_color = 3'd2; setTables(1);
    runFrame(1'b0, 100, 100, 1'b0, 1'b0, -1);

    // Three-cycle back-pressure while (1,0) is presented.
    runFrame(1'b0, 100, 100, 1'b1, 1'b0, -1);

    // Clear mode with every layer hitting.
    bg_color = 3'd7; setTables(2);
    runFrame(1'b1, 100, 100, 1'b0, 1'b0, -1);

    // Repeated frame_start requests during the frame.
    bg_color = 3'd1; setTables(3);
    runFrame(1'b0, 100, 100, 1'b0, 1'b1, -1);

    // Reset while pixel 4 is presented, then a fresh frame from the origin.
    setTables(3);
    runFrame(1'b0, 100, 100, 1'b0, 1'b0, 4);
    runFrame(1'b0, 100, 100, 1'b0, 1'b0, -1);

    // Random back-pressure, enable gaps, start requests and layer contents.
    for (int f = 0; f < 6; f++) begin
      bg_color = COLW'($urandom_range(7));
      setTables(3);
      runFrame(1'($urandom_range(1)), 60, 70, 1'b0, 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layered_pixel_scanner.md
LAYERED_PIXEL_SCANNER -- requirements
Module: layered_pixel_scanner

Interface
REQ-001 Parameter XMAX, default 159: last x coordinate of the frame.
REQ-002 Parameter YMAX, default 119: last y coordinate of the frame.
REQ-003 Parameter CW, default 8: coordinate width; XMAX and YMAX each SHALL fit in CW bits.
REQ-004 Parameter COLW, default 3: colour width.
REQ-005 Parameter NL, default 4: number of layer channels, range 1..8.
REQ-006 Parameter LAT, default 2: fixed latency of the layer sources from coordinate to hit/colour, range 0..4.
REQ-007 clk  in  1  clock.
REQ-008 resetn  in  1  reset, synchronous, active-low.
REQ-009 enable  in  1  run permit; while low, no coordinate is issued.
REQ-010 frame_start  in  1  one-cycle request to start a frame scan.
REQ-011 clear_mode  in  1  sampled with frame_start; 1 = plot bg_color everywhere.
REQ-012 bg_color  in  COLW  background colour.
REQ-013 layer_hit  in  NL  per-layer hit flag, valid LAT cycles after the matching req_x/req_y.
REQ-014 layer_color  in  NL*COLW  per-layer colour; layer i occupies bits [i*COLW +: COLW].
REQ-015 req_x, req_y  out  CW each  coordinate issued to the layer sources.
REQ-016 plot_x, plot_y  out  CW each  coordinate of the output pixel.
REQ-017 plot_color  out  COLW  composited colour of the output pixel.
REQ-018 plot  out  1  output pixel valid.
REQ-019 plot_ready  in  1  sink accepts the pixel when plot && plot_ready.
REQ-020 busy  out  1  high from frame acceptance until frame_done.
REQ-021 frame_done  out  1  one-cycle pulse in the cycle after the last pixel (XMAX,YMAX) is accepted.

Function
REQ-022 FSM states: IDLE, SCAN, REPLAY; the FSM SHALL leave IDLE only on frame_start && enable, with req = (0,0) and clear_mode latched.
REQ-023 frame_start in SCAN or REPLAY SHALL be ignored.
REQ-024 In SCAN, with enable high and no stall, the issue coordinate SHALL advance once per cycle in raster order: x+1 while x<XMAX, otherwise x=0 and y+1, and y wraps from YMAX to 0.
REQ-025 After the issue of (XMAX,YMAX), no further coordinates SHALL be issued; the FSM SHALL wait for acceptance of that pixel and then pulse frame_done and return to IDLE.
REQ-026 The module SHALL carry each issued coordinate and a valid bit through an LAT-stage delay line, plus one output register stage, so that plot asserts LAT+1 cycles after issue.
REQ-027 Compositing: plot_color SHALL be layer_color[i] for the lowest index i with layer_hit[i]=1; with no hit, or clear_mode=1, it SHALL be bg_color.
REQ-028 Stall: if plot && !plot_ready, the output register SHALL hold and all in-flight valid bits SHALL clear.
REQ-028a During a stall the FSM SHALL enter REPLAY and rewind the issue coordinate to the raster successor of plot_x/plot_y.
REQ-029 REPLAY SHALL return to SCAN in the cycle the held pixel is accepted; issue then resumes from the rewound coordinate, giving an LAT+1 refill gap.
REQ-030 No pixel SHALL be plotted twice or skipped across any number of stalls.
REQ-031 If enable goes low mid-frame, issue SHALL pause and in-flight pixels SHALL drain to the output normally; issue resumes from the next coordinate when enable returns.
REQ-032 With LAT=0, the layer inputs SHALL be sampled in the same cycle as req_x/req_y.

Reset
REQ-033 While resetn is low at clk: FSM=IDLE; req_x=req_y=plot_x=plot_y=0; plot_color=0; plot=busy=frame_done=0; all valid bits clear.
REQ-034 Reset mid-frame SHALL abort the frame without a frame_done pulse.

Structure
REQ-035 The FSM state encodings and the default XMAX, YMAX, CW and COLW values SHALL live in the shared DinoGame constants package.
REQ-036 The priority compositor SHALL be one sub-module, layer_priority_mux (NL, COLW), that is purely combinational.

Verification
REQ-037 XMAX=3, YMAX=1, LAT=2, plot_ready=1, no hits: frame_start -> first plot at cycle 3, 8 pixels (0,0)..(3,1) all bg_color, frame_done one cycle after the last pixel is accepted.
REQ-038 Layers 1 and 3 both hit at (2,0), colours 5 and 6 -> plot_color=5 at (2,0); layer 3 alone hits -> 6.
REQ-039 plot_ready is low for 3 cycles while (1,0) is presented -> (1,0) is held, then the sequence (1,0),(2,0),(3,0) occurs with no duplicate and no gap in the coordinates.
REQ-040 clear_mode=1 with every layer hitting -> all pixels are bg_color.
REQ-041 frame_start pulsed again mid-frame -> ignored; exactly 8 pixels and one frame_done.
REQ-042 resetn is low at pixel 4 -> plot=0 and busy=0 next cycle, no frame_done; a new frame_start restarts at (0,0).
